id_ex_stage: RTL

- ID/EX pipeline stage of the pipelined MIPS CPU; sits directly upstream of the ALU.
- Latches decoded operands and control from ID.
- Resolves EX/MEM and MEM/WB forwarding, then drives the ALU inputs A, B, ALUFun and Sign.
- Detects load-use hazards and inserts bubbles.

---
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble insertion.
// Optional: define ID_EX_BUBBLE_CNT_EN to add a saturating bubble_cnt output.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_wbdst,
    input  logic [5:0]    id_alufun,
    input  logic          id_sign,
    input  logic          id_alusrc1,
    input  logic          id_alusrc2,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          stall,
    input  logic          flush,
    input  logic          exm_regwrite,
    input  logic [RW-1:0] exm_wbdst,
    input  logic [DW-1:0] exm_result,
    input  logic          mw_regwrite,
    input  logic [RW-1:0] mw_wbdst,
    input  logic [DW-1:0] mw_result,
    output logic          load_use,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [5:0]    alu_fun,
    output logic          alu_sign,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_wbdst,
    output logic          ex_regwrite,
    output logic          ex_memread,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [31:0]   bubble_cnt,
`endif
    output logic          ex_memwrite
);

    logic          valid_q;
    logic [DW-1:0] pc_q, rs_data_q, rt_data_q, imm_q;
    logic [4:0]    shamt_q;
    logic [RW-1:0] rs_q, rt_q, wbdst_q;
    logic [5:0]    alufun_q;
    logic          sign_q, alusrc1_q, alusrc2_q;
    logic          regwrite_q, memread_q, memwrite_q;
    logic [DW-1:0] rs_fwd, rt_fwd;

    assign load_use = valid_q & memread_q & (wbdst_q != '0) & id_valid &
                      ((wbdst_q == id_rs) | (wbdst_q == id_rt));

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            wbdst_q    <= '0;
            alufun_q   <= '0;
            sign_q     <= 1'b0;
            alusrc1_q  <= 1'b0;
            alusrc2_q  <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else if (flush || (!stall && load_use)) begin
            // Bubble: data fields keep their old contents, they are don't-care.
            valid_q    <= 1'b0;
            alufun_q   <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else if (!stall) begin
            valid_q    <= id_valid;
            pc_q       <= id_pc;
            rs_data_q  <= id_rs_data;
            rt_data_q  <= id_rt_data;
            imm_q      <= id_imm;
            shamt_q    <= id_shamt;
            rs_q       <= id_rs;
            rt_q       <= id_rt;
            wbdst_q    <= id_wbdst;
            alufun_q   <= id_alufun;
            sign_q     <= id_sign;
            alusrc1_q  <= id_alusrc1;
            alusrc2_q  <= id_alusrc2;
            regwrite_q <= id_regwrite;
            memread_q  <= id_memread;
            memwrite_q <= id_memwrite;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    always_comb begin
        rs_fwd = rs_data_q;
        if (exm_regwrite && exm_wbdst != '0 && exm_wbdst == rs_q)
            rs_fwd = exm_result;
        else if (mw_regwrite && mw_wbdst != '0 && mw_wbdst == rs_q)
            rs_fwd = mw_result;

        rt_fwd = rt_data_q;
        if (exm_regwrite && exm_wbdst != '0 && exm_wbdst == rt_q)
            rt_fwd = exm_result;
        else if (mw_regwrite && mw_wbdst != '0 && mw_wbdst == rt_q)
            rt_fwd = mw_result;
    end

    assign alu_a         = alusrc1_q ? {{(DW-5){1'b0}}, shamt_q} : rs_fwd;
    assign alu_b         = alusrc2_q ? imm_q : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign alu_fun       = alufun_q;
    assign alu_sign      = sign_q;
    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_wbdst      = wbdst_q;
    assign ex_regwrite   = regwrite_q & valid_q;
    assign ex_memread    = memread_q & valid_q;
    assign ex_memwrite   = memwrite_q & valid_q;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if ((flush || (!stall && load_use)) && cnt_q != 32'hFFFF_FFFF)
            cnt_q <= cnt_q + 32'd1;
    end

    assign bubble_cnt = cnt_q;
`endif

endmodule
